// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : MEM-stage load/store sequencer in front of a doubleword-wide
//            Data_Memory; read-modify-write for sub-doubleword stores.
// Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
    parameter int XLEN       = 64,
    parameter int ALIGN_BITS = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_write_data,
    output logic            mem_write,
    output logic            mem_read,
    input  logic [XLEN-1:0] mem_read_data
);

    localparam int c_SHIFT_W = ALIGN_BITS + 3;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_READ   = 3'd1;
    localparam logic [2:0] c_WRITE  = 3'd2;
    localparam logic [2:0] c_RMW_RD = 3'd3;
    localparam logic [2:0] c_RMW_WR = 3'd4;
    localparam logic [2:0] c_RESP   = 3'd5;

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic                 r_write;
    logic [2:0]           r_funct3;
    logic [XLEN-1:0]      r_addr;
    logic [XLEN-1:0]      r_wdata;
    logic [XLEN-1:0]      r_merged;
    logic [XLEN-1:0]      r_rdata;
    logic                 r_fault;

    logic                 w_accept;
    logic                 w_misaligned;
    logic                 w_illegal;
    logic                 w_req_fault;
    logic [c_SHIFT_W-1:0] w_shamt;
    logic [XLEN-1:0]      w_rd_shift;
    logic                 w_sign;
    logic [XLEN-1:0]      w_load_ext;
    logic [XLEN-1:0]      w_mask;
    logic [XLEN-1:0]      w_merged;

    assign w_accept = req_valid && (r_state == c_IDLE);

    // Natural alignment: the low size bits of the address must be zero.
    always_comb begin
        w_misaligned = 1'b0;
        case (req_funct3[1:0])
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = req_addr[0];
            2'd2:    w_misaligned = |req_addr[1:0];
            default: w_misaligned = |req_addr[2:0];
        endcase
    end

    assign w_illegal   = req_write ? req_funct3[2] : (req_funct3 == 3'b111);
    assign w_req_fault = w_misaligned || w_illegal;

    assign w_shamt    = {r_addr[ALIGN_BITS-1:0], 3'b000};
    assign w_rd_shift = mem_read_data >> w_shamt;
    assign w_sign     = ~r_funct3[2];

    always_comb begin
        w_load_ext = w_rd_shift;
        w_mask     = '1;
        case (r_funct3[1:0])
            2'd0: begin
                w_load_ext = {{(XLEN-8){w_sign & w_rd_shift[7]}}, w_rd_shift[7:0]};
                w_mask     = {{(XLEN-8){1'b0}}, 8'hFF};
            end
            2'd1: begin
                w_load_ext = {{(XLEN-16){w_sign & w_rd_shift[15]}}, w_rd_shift[15:0]};
                w_mask     = {{(XLEN-16){1'b0}}, 16'hFFFF};
            end
            2'd2: begin
                w_load_ext = {{(XLEN-32){w_sign & w_rd_shift[31]}}, w_rd_shift[31:0]};
                w_mask     = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
            end
            default: begin
                w_load_ext = w_rd_shift;
                w_mask     = '1;
            end
        endcase
    end

    assign w_merged = (mem_read_data & ~(w_mask << w_shamt)) |
                      ((r_wdata & w_mask) << w_shamt);

    always_comb begin
        w_next_state   = r_state;
        req_ready      = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_write_data = '0;
        resp_valid     = 1'b0;
        case (r_state)
            c_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_req_fault)                w_next_state = c_RESP;
                    else if (!req_write)            w_next_state = c_READ;
                    else if (req_funct3[1:0] == 2'd3) w_next_state = c_WRITE;
                    else                            w_next_state = c_RMW_RD;
                end
            end
            c_READ: begin
                mem_read     = 1'b1;
                w_next_state = c_RESP;
            end
            c_WRITE: begin
                mem_write      = 1'b1;
                mem_write_data = r_wdata;
                w_next_state   = c_RESP;
            end
            c_RMW_RD: begin
                mem_read     = 1'b1;
                w_next_state = c_RMW_WR;
            end
            c_RMW_WR: begin
                mem_write      = 1'b1;
                mem_write_data = r_merged;
                w_next_state   = c_RESP;
            end
            c_RESP: begin
                resp_valid   = 1'b1;
                w_next_state = c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Response registers only move on the edge entering RESP, so they hold
    // the previous result while a new request is in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_IDLE;
            r_write  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_merged <= '0;
            r_rdata  <= '0;
            r_fault  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_write  <= req_write;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                if (w_req_fault) begin
                    r_rdata <= '0;
                    r_fault <= 1'b1;
                end
            end
            if (r_state == c_RMW_RD) begin
                r_merged <= w_merged;
            end
            if ((r_state == c_READ) || (r_state == c_WRITE) || (r_state == c_RMW_WR)) begin
                r_rdata <= r_write ? '0 : w_load_ext;
                r_fault <= 1'b0;
            end
        end
    end

    assign mem_addr   = {r_addr[XLEN-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
    assign resp_rdata = r_rdata;
    assign resp_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Self-checking bench; byte-array reference memory predicts loads,
//            faults, latency and memory activity for directed/random traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic [63:0] mem_addr;
    logic [63:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [63:0] mem_read_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          lat;
        logic [63:0] rdata;
        logic        fault;
        int          nrd;
        int          nwr;
        int          both;
        logic [63:0] wr_addr;
        logic [63:0] wr_data;
        int          acc_cyc;
    } resp_t;

    typedef struct packed {
        logic        w;
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] wd;
        logic [63:0] rd;
        logic        flt;
        logic [3:0]  lat;
        logic [1:0]  nrd;
        logic [1:0]  nwr;
        logic [63:0] mwd;
    } vec_t;

    load_store_unit #(.XLEN(64), .ALIGN_BITS(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Data_Memory stand-in: combinational read, write on rising edge
    logic [63:0] dmem [0:31] = '{default: 64'd0};
    assign mem_read_data = dmem[mem_addr[7:3]];
    always @(posedge clk) if (mem_write) dmem[mem_addr[7:3]] <= mem_write_data;

    // Reference model: flat byte-addressed memory
    logic [7:0] ref_mem [0:255] = '{default: 8'd0};

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a);
        int n;
        logic [63:0] v;
        n = 1 << f3[1:0];
        v = '0;
        for (int i = 0; i < n; i++) v = v | (64'(ref_mem[8'(int'(a[7:0]) + i)]) << (8 * i));
        if (!f3[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        return v;
    endfunction

    task automatic model_txn(input logic w, input logic [2:0] f3, input logic [63:0] a,
                             input logic [63:0] wd, output resp_t e);
        int n;
        bit misal, illeg;
        e = '{default: 0};
        n = 1 << f3[1:0];
        misal = (int'(a[2:0]) % n) != 0;
        illeg = w ? f3[2] : (f3 == 3'b111);
        if (misal || illeg) begin
            e.fault = 1'b1;
            e.lat   = 1;
            return;
        end
        if (w) begin
            for (int i = 0; i < n; i++) ref_mem[8'(int'(a[7:0]) + i)] = wd[8*i +: 8];
            e.nwr = 1;
            e.nrd = (n < 8) ? 1 : 0;
            e.lat = (n < 8) ? 3 : 2;
        end else begin
            e.rdata = ref_load(f3, a);
            e.nrd   = 1;
            e.lat   = 2;
        end
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, output resp_t r);
        int k;
        r = '{default: 0};
        r.lat = -1;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        r.acc_cyc = cyc;
        req_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (mem_read) r.nrd++;
            if (mem_write) begin
                r.nwr++;
                r.wr_addr = mem_addr;
                r.wr_data = mem_write_data;
            end
            if (mem_read && mem_write) r.both++;
            if (resp_valid) begin
                r.lat   = i;
                r.rdata = resp_rdata;
                r.fault = resp_fault;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 5;
            if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
            if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
                errors++; $display("FAIL reset_mem_rw: got rd=%b wr=%b want 0/0", mem_read, mem_write);
            end
            if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
            if (mem_addr !== 64'd0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
            if (resp_rdata !== 64'd0 || resp_fault !== 1'b0 || mem_write_data !== 64'd0) begin
                errors++;
                $display("FAIL reset_data: got rdata=%h fault=%b wdata=%h want 0", resp_rdata, resp_fault, mem_write_data);
            end
            req_valid  = ~req_valid;
            req_write  = 1'($urandom_range(0, 1));
            req_funct3 = 3'($urandom_range(0, 7));
            req_addr   = 64'($urandom_range(0, 255));
        end
        @(negedge clk);
        reset_n   = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: got ready=%b valid=%b want 1/0", req_ready, resp_valid);
        end
    endtask

    task automatic test_directed();
        vec_t  v [10];
        resp_t r, e;
        v[0] = '{1'b1, 3'b011, 64'h10, 64'h1122334455667788, 64'h0, 1'b0, 4'd2, 2'd0, 2'd1, 64'h1122334455667788};
        v[1] = '{1'b0, 3'b011, 64'h10, 64'h0, 64'h1122334455667788, 1'b0, 4'd2, 2'd1, 2'd0, 64'h0};
        v[2] = '{1'b0, 3'b000, 64'h10, 64'h0, 64'hFFFFFFFFFFFFFF88, 1'b0, 4'd2, 2'd1, 2'd0, 64'h0};
        v[3] = '{1'b0, 3'b100, 64'h10, 64'h0, 64'h88, 1'b0, 4'd2, 2'd1, 2'd0, 64'h0};
        v[4] = '{1'b0, 3'b001, 64'h16, 64'h0, 64'h1122, 1'b0, 4'd2, 2'd1, 2'd0, 64'h0};
        v[5] = '{1'b0, 3'b010, 64'h14, 64'h0, 64'h11223344, 1'b0, 4'd2, 2'd1, 2'd0, 64'h0};
        v[6] = '{1'b1, 3'b001, 64'h12, 64'hABCD, 64'h0, 1'b0, 4'd3, 2'd1, 2'd1, 64'h11223344ABCD7788};
        v[7] = '{1'b0, 3'b011, 64'h10, 64'h0, 64'h11223344ABCD7788, 1'b0, 4'd2, 2'd1, 2'd0, 64'h0};
        v[8] = '{1'b0, 3'b010, 64'h12, 64'h0, 64'h0, 1'b1, 4'd1, 2'd0, 2'd0, 64'h0};
        v[9] = '{1'b0, 3'b111, 64'h10, 64'h0, 64'h0, 1'b1, 4'd1, 2'd0, 2'd0, 64'h0};
        for (int i = 0; i < 10; i++) begin
            model_txn(v[i].w, v[i].f3, v[i].a, v[i].wd, e);
            issue(v[i].w, v[i].f3, v[i].a, v[i].wd, r);
            checks += 4;
            if (r.lat !== int'(v[i].lat)) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, r.lat, v[i].lat); end
            if (r.rdata !== v[i].rd || r.fault !== v[i].flt) begin
                errors++; $display("FAIL dir%0d_resp: got %h/%b want %h/%b", i, r.rdata, r.fault, v[i].rd, v[i].flt);
            end
            if (r.nrd !== int'(v[i].nrd) || r.nwr !== int'(v[i].nwr)) begin
                errors++; $display("FAIL dir%0d_mem_cycles: got rd=%0d wr=%0d want %0d/%0d", i, r.nrd, r.nwr, v[i].nrd, v[i].nwr);
            end
            if (r.both !== 0) begin errors++; $display("FAIL dir%0d_rd_wr_overlap: got %0d want 0", i, r.both); end
            if (v[i].nwr == 2'd1) begin
                checks++;
                if (r.wr_addr !== (v[i].a & ~64'h7) || r.wr_data !== v[i].mwd) begin
                    errors++;
                    $display("FAIL dir%0d_mem_write: got %h@%h want %h@%h", i, r.wr_data, r.wr_addr, v[i].mwd, v[i].a & ~64'h7);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        resp_t r;
        int    nresp;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 64'h10; req_wdata = 64'h5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1) begin errors++; $display("FAIL abort_rmw_read: got %b want 1", mem_read); end
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1) begin errors++; $display("FAIL abort_rmw_write: got %b want 1", mem_write); end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0) begin errors++; $display("FAIL abort_async_drop: got %b want 0", mem_write); end
        @(negedge clk);
        reset_n = 1'b1;
        nresp = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        checks++;
        if (nresp != 0) begin errors++; $display("FAIL abort_no_resp: got %0d pulses want 0", nresp); end
        issue(1'b0, 3'b011, 64'h10, 64'h0, r);
        checks++;
        if (r.rdata !== 64'h11223344ABCD7788 || r.rdata !== ref_load(3'b011, 64'h10)) begin
            errors++; $display("FAIL abort_word_intact: got %h want %h", r.rdata, 64'h11223344ABCD7788);
        end
    endtask

    task automatic test_back_to_back();
        resp_t r1, r2, e;
        model_txn(1'b0, 3'b011, 64'h10, 64'h0, e);
        issue(1'b0, 3'b011, 64'h10, 64'h0, r1);
        model_txn(1'b0, 3'b100, 64'h18, 64'h0, e);
        issue(1'b0, 3'b100, 64'h18, 64'h0, r2);
        checks++;
        if (r2.acc_cyc - r1.acc_cyc != 3) begin errors++; $display("FAIL b2b_load_interval: got %0d want 3", r2.acc_cyc - r1.acc_cyc); end
        model_txn(1'b1, 3'b000, 64'h23, 64'hC3, e);
        issue(1'b1, 3'b000, 64'h23, 64'hC3, r1);
        model_txn(1'b0, 3'b000, 64'h23, 64'h0, e);
        issue(1'b0, 3'b000, 64'h23, 64'h0, r2);
        checks += 2;
        if (r2.acc_cyc - r1.acc_cyc != 4) begin errors++; $display("FAIL b2b_rmw_interval: got %0d want 4", r2.acc_cyc - r1.acc_cyc); end
        if (r2.rdata !== e.rdata) begin errors++; $display("FAIL b2b_rmw_readback: got %h want %h", r2.rdata, e.rdata); end
        issue(1'b1, 3'b111, 64'h20, 64'h0, r1);
        model_txn(1'b0, 3'b001, 64'h22, 64'h0, e);
        issue(1'b0, 3'b001, 64'h22, 64'h0, r2);
        checks++;
        if (r2.acc_cyc - r1.acc_cyc != 2) begin errors++; $display("FAIL b2b_fault_interval: got %0d want 2", r2.acc_cyc - r1.acc_cyc); end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== e.rdata) begin
            errors++; $display("FAIL resp_pulse_hold: got valid=%b rdata=%h want 0/%h", resp_valid, resp_rdata, e.rdata);
        end
    endtask

    task automatic test_random();
        resp_t       r, e;
        logic        w;
        logic [2:0]  f3;
        logic [63:0] a, wd;
        for (int t = 0; t < 60; t++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 64'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
            wd = {$urandom, $urandom};
            model_txn(w, f3, a, wd, e);
            issue(w, f3, a, wd, r);
            checks += 4;
            if (r.lat !== e.lat) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", t, r.lat, e.lat); end
            if (r.rdata !== e.rdata || r.fault !== e.fault) begin
                errors++;
                $display("FAIL rnd%0d_resp w=%b f3=%0d a=%h: got %h/%b want %h/%b", t, w, f3, a, r.rdata, r.fault, e.rdata, e.fault);
            end
            if (r.nrd !== e.nrd || r.nwr !== e.nwr) begin
                errors++; $display("FAIL rnd%0d_mem_cycles: got rd=%0d wr=%0d want %0d/%0d", t, r.nrd, r.nwr, e.nrd, e.nwr);
            end
            if (r.both !== 0) begin errors++; $display("FAIL rnd%0d_rd_wr_overlap: got %0d want 0", t, r.both); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
